// File: rtl/io_uart_pkg.sv
// io_uart_pkg: register offsets, STAT/CTRL bit positions and FSM states for io_uart_tx
package io_uart_pkg;
   localparam logic [2:0] OFF_DATA = 3'd0;
   localparam logic [2:0] OFF_STAT = 3'd1;
   localparam logic [2:0] OFF_CTRL = 3'd2;
   localparam logic [2:0] OFF_DIVL = 3'd3;
   localparam logic [2:0] OFF_DIVH = 3'd4;
   localparam int STAT_FULL   = 0;
   localparam int STAT_EMPTY  = 1;
   localparam int STAT_BUSY   = 2;
   localparam int STAT_OVF    = 3;
   localparam int CTRL_EN     = 0;
   localparam int CTRL_IRQ_EN = 1;
   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
endpackage

// File: rtl/io_fifo.sv
// io_fifo: synchronous FIFO; a push while full is taken only if a pop happens in the same cycle
// clk/reset (sync, active-low); push/wr_data write side; pop/rd_data read side (rd_data shows the head);
// full/empty status flags
module io_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic do_push, do_pop;
   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rd_data = mem[rd_ptr];
   always_ff @(posedge clk)
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/io_uart_tx.sv
// io_uart_tx: 8N1 UART transmitter on the 5-bit {bank, offset} I/O register bus
// clk, reset (sync, active-low); pause holds io_readdata; io_readaddr -> io_readdata (1-cycle registered read);
// io_writeaddr/io_writedata/io_write_en register writes; irq level interrupt when drained; tx serial out, idle high
module io_uart_tx
   import io_uart_pkg::*;
#(
   parameter logic [1:0]  BANK       = 2'd0,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd433
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pause,
   input  logic [4:0] io_readaddr,
   output logic [7:0] io_readdata,
   input  logic [4:0] io_writeaddr,
   input  logic [7:0] io_writedata,
   input  logic       io_write_en,
   output logic       irq,
   output logic       tx
);
   state_t state, state_n;
   logic enable, irq_en, overflow;
   logic [15:0] div, baud_cnt;
   logic [2:0] bit_cnt, woff;
   logic [7:0] shreg, head, rd_val;
   logic wr, push, pop, full, empty, tick;
   assign wr   = io_write_en && io_writeaddr[4:3] == BANK;
   assign woff = io_writeaddr[2:0];
   assign push = wr && woff == OFF_DATA;
   // baud_cnt counts down from the divisor latched at each bit start; zero marks the last clock of a bit
   assign tick = baud_cnt == '0;
   assign tx   = state == ST_START ? 1'b0 : state == ST_DATA ? shreg[0] : 1'b1;
   assign irq  = irq_en & empty & (state == ST_IDLE);
   io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push(push),
      .wr_data(io_writedata),
      .pop(pop),
      .rd_data(head),
      .full(full),
      .empty(empty)
   );
   always_comb begin
      state_n = state;
      pop = 1'b0;
      case (state)
         ST_IDLE:  if (enable && !empty) begin
            pop = 1'b1;
            state_n = ST_START;
         end
         ST_START: if (tick) state_n = ST_DATA;
         ST_DATA:  if (tick && bit_cnt == 3'd7) state_n = ST_STOP;
         ST_STOP:  if (tick) begin
            pop = enable & ~empty;
            state_n = pop ? ST_START : ST_IDLE;
         end
         default:  state_n = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk)
      state <= !reset ? ST_IDLE : state_n;
   always_ff @(posedge clk)
      if (!reset) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
      end else if (pop) begin
         shreg    <= head;
         baud_cnt <= div;
         bit_cnt  <= '0;
      end else if (state != ST_IDLE) begin
         baud_cnt <= tick ? div : baud_cnt - 1'b1;
         if (tick && state == ST_DATA) begin
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   always_ff @(posedge clk)
      if (!reset) begin
         enable   <= 1'b0;
         irq_en   <= 1'b0;
         div      <= DIV_RESET;
         overflow <= 1'b0;
      end else begin
         if (wr && woff == OFF_CTRL) begin
            enable <= io_writedata[CTRL_EN];
            irq_en <= io_writedata[CTRL_IRQ_EN];
         end
         if (wr && woff == OFF_DIVL) div[7:0] <= io_writedata;
         if (wr && woff == OFF_DIVH) div[15:8] <= io_writedata;
         if (wr && woff == OFF_STAT) overflow <= 1'b0;
         else if (push && full && !pop) overflow <= 1'b1;
      end
   always_comb begin
      rd_val = '0;
      if (io_readaddr[4:3] == BANK)
         case (io_readaddr[2:0])
            OFF_STAT: begin
               rd_val[STAT_FULL]  = full;
               rd_val[STAT_EMPTY] = empty;
               rd_val[STAT_BUSY]  = state != ST_IDLE;
               rd_val[STAT_OVF]   = overflow;
            end
            OFF_CTRL: begin
               rd_val[CTRL_EN]     = enable;
               rd_val[CTRL_IRQ_EN] = irq_en;
            end
            OFF_DIVL: rd_val = div[7:0];
            OFF_DIVH: rd_val = div[15:8];
            default:  rd_val = '0;
         endcase
   end
   always_ff @(posedge clk)
      if (!reset) io_readdata <= '0;
      else if (!pause) io_readdata <= rd_val;
endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: self-checking bench; expected tx waveform built frame by frame from the 8N1 rules
module tb_io_uart_tx;
   import io_uart_pkg::*;
   localparam logic [1:0] BANK = 2'd2;
   localparam int DEPTH = 4;
   logic clk = 1'b0, reset = 1'b0, pause = 1'b0, io_write_en = 1'b0;
   logic irq, tx;
   logic [4:0] io_readaddr = '0, io_writeaddr = '0;
   logic [7:0] io_readdata, io_writedata = '0;
   int n_tests = 0, n_fail = 0;
   logic exp_tx[$];
   int sw_k[$];
   logic [4:0] sw_a[$];
   logic [7:0] sw_d[$];
   logic irq_mode = 1'b0;

   io_uart_tx #(.BANK(BANK), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd433)) dut (
      .clk(clk),
      .reset(reset),
      .pause(pause),
      .io_readaddr(io_readaddr),
      .io_readdata(io_readdata),
      .io_writeaddr(io_writeaddr),
      .io_writedata(io_writedata),
      .io_write_en(io_write_en),
      .irq(irq),
      .tx(tx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] off, input logic [7:0] d);
      io_writeaddr = {BANK, off};
      io_writedata = d;
      io_write_en = 1'b1;
      step();
      io_write_en = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [7:0] d);
      io_readaddr = a;
      step();
      d = io_readdata;
   endtask

   task automatic chk_reg(input string tag, input logic [2:0] off, input logic [7:0] exp);
      logic [7:0] d;
      rd({BANK, off}, d);
      check(tag, 32'(d), 32'(exp));
   endtask

   // one frame: start, 8 data bits LSB first, stop; symbols before index sw last d0+1 clocks, the rest d1+1
   function automatic void add_frame(input logic [7:0] b, input int d0, input int d1, input int sw);
      for (int i = 0; i < 10; i++) begin
         logic lvl;
         lvl = i == 0 ? 1'b0 : i == 9 ? 1'b1 : b[i-1];
         for (int c = 0; c <= (i < sw ? d0 : d1); c++) exp_tx.push_back(lvl);
      end
   endfunction

   task automatic sched(input int k, input logic [2:0] off, input logic [7:0] d);
      sw_k.push_back(k);
      sw_a.push_back({BANK, off});
      sw_d.push_back(d);
   endtask

   // cycle k: scheduled write accepted at edge k; tx after edge k must equal exp_tx[k-1] (idle high otherwise)
   task automatic run(input string tag, input int extra);
      int errs, ierrs, n;
      logic etx, eirq;
      errs = 0;
      ierrs = 0;
      n = exp_tx.size() + extra;
      for (int k = 0; k <= n; k++) begin
         io_write_en = 1'b0;
         for (int j = 0; j < sw_k.size(); j++)
            if (sw_k[j] == k) begin
               io_write_en = 1'b1;
               io_writeaddr = sw_a[j];
               io_writedata = sw_d[j];
            end
         step();
         io_write_en = 1'b0;
         etx = (k >= 1 && k - 1 < exp_tx.size()) ? exp_tx[k-1] : 1'b1;
         eirq = irq_mode && k > exp_tx.size();
         if (tx !== etx) errs++;
         if (irq !== eirq) ierrs++;
      end
      check({tag, " tx"}, 32'(errs), 32'd0);
      check({tag, " irq"}, 32'(ierrs), 32'd0);
      exp_tx.delete();
      sw_k.delete();
      sw_a.delete();
      sw_d.delete();
   endtask

   initial begin
      logic [7:0] d, b;
      int dv, n;
      logic ie;
      reset = 1'b0;
      step();
      step();
      check("rst tx", 32'(tx), 32'd1);
      check("rst irq", 32'(irq), 32'd0);
      check("rst rdata", 32'(io_readdata), 32'd0);
      reset = 1'b1;
      chk_reg("rst DATA", OFF_DATA, 8'h00);
      chk_reg("rst STAT", OFF_STAT, 8'h02);
      chk_reg("rst CTRL", OFF_CTRL, 8'h00);
      chk_reg("rst DIVL", OFF_DIVL, 8'hB1);
      chk_reg("rst DIVH", OFF_DIVH, 8'h01);
      chk_reg("rst off5", 3'd5, 8'h00);

      wr(OFF_DIVL, 8'd3);
      wr(OFF_DIVH, 8'd0);
      wr(OFF_CTRL, 8'h01);
      sched(0, OFF_DATA, 8'hA5);
      add_frame(8'hA5, 3, 3, 10);
      run("single", 3);

      wr(OFF_DIVL, 8'd0);
      for (int i = 0; i < 6; i++) begin
         b = 8'(8'h11 * (i + 1));
         sched(i, OFF_DATA, b);
         if (i < DEPTH + 1) add_frame(b, 0, 0, 10);
      end
      run("b2b", 3);
      chk_reg("ovf set", OFF_STAT, 8'h0A);
      wr(OFF_STAT, 8'h00);
      chk_reg("ovf clr", OFF_STAT, 8'h02);

      wr(OFF_DIVL, 8'd2);
      wr(OFF_CTRL, 8'h03);
      check("irq idle", 32'(irq), 32'd1);
      irq_mode = 1'b1;
      sched(0, OFF_DATA, 8'h3C);
      add_frame(8'h3C, 2, 2, 10);
      run("irq", 3);
      check("irq drained", 32'(irq), 32'd1);
      wr(OFF_CTRL, 8'h01);
      check("irq en clr", 32'(irq), 32'd0);
      irq_mode = 1'b0;

      io_writeaddr = {2'd1, OFF_CTRL};
      io_writedata = 8'h00;
      io_write_en = 1'b1;
      step();
      io_write_en = 1'b0;
      chk_reg("bank ctrl", OFF_CTRL, 8'h01);
      rd({2'd0, OFF_STAT}, d);
      check("bank rd", 32'(d), 32'd0);
      wr(OFF_DIVL, 8'd3);
      chk_reg("pause pre", OFF_STAT, 8'h02);
      pause = 1'b1;
      io_readaddr = {BANK, OFF_DIVL};
      for (int i = 0; i < 3; i++) begin
         step();
         check("pause hold", 32'(io_readdata), 32'h02);
      end
      pause = 1'b0;
      step();
      check("pause rel", 32'(io_readdata), 32'h03);

      sched(0, OFF_DATA, 8'h55);
      sched(18, OFF_DIVL, 8'd1);
      add_frame(8'h55, 3, 1, 5);
      run("mid div", 3);

      sched(0, OFF_DATA, 8'h96);
      sched(1, OFF_DATA, 8'h3E);
      sched(5, OFF_CTRL, 8'h00);
      add_frame(8'h96, 1, 1, 10);
      run("en clr", 6);
      chk_reg("held stat", OFF_STAT, 8'h00);
      sched(0, OFF_CTRL, 8'h01);
      add_frame(8'h3E, 1, 1, 10);
      run("resume", 3);

      wr(OFF_DIVL, 8'd3);
      wr(OFF_DATA, 8'h00);
      for (int i = 0; i < 10; i++) step();
      check("mid frame tx", 32'(tx), 32'd0);
      reset = 1'b0;
      step();
      check("mid rst tx", 32'(tx), 32'd1);
      reset = 1'b1;
      step();
      check("post rst tx", 32'(tx), 32'd1);
      chk_reg("post rst STAT", OFF_STAT, 8'h02);
      chk_reg("post rst DIVL", OFF_DIVL, 8'hB1);

      wr(OFF_DIVH, 8'd0);
      for (int it = 0; it < 10; it++) begin
         dv = $urandom_range(0, 3);
         n = $urandom_range(1, 6);
         ie = 1'($urandom_range(0, 1));
         wr(OFF_DIVL, 8'(dv));
         wr(OFF_CTRL, {6'b0, ie, 1'b1});
         irq_mode = ie;
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            sched(i, OFF_DATA, b);
            if (i < DEPTH + 1) add_frame(b, dv, dv, 10);
         end
         run($sformatf("rand%0d", it), 3);
         chk_reg($sformatf("rand%0d stat", it), OFF_STAT, n > DEPTH + 1 ? 8'h0A : 8'h02);
         wr(OFF_STAT, 8'h00);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/io_uart_tx.md
# io_uart_tx

UART transmit peripheral that sits on the responder side of the processor's 5-bit I/O register bus, the bus the memory controller drives as {bank, offset}. Software writes bytes into a small FIFO through I/O registers. The block serialises them as 8N1 frames on a single output pin. It drives one level-sensitive line of the 8-bit I/O interrupt vector when transmission drains.

## Interface
Parameters:
- BANK, 2'd0: bank this peripheral decodes; it responds when addr[4:3] == BANK.
- FIFO_DEPTH, 4: transmit FIFO entries; power of two, minimum 2.
- DIV_RESET, 16'd433: reset value of the baud divisor.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low; low on a rising edge clears all state
- pause  in  1  pipeline stall; holds io_readdata
- io_readaddr  in  5  {bank, offset} read address
- io_readdata  out  8  registered read data
- io_writeaddr  in  5  {bank, offset} write address
- io_writedata  in  8  write data
- io_write_en  in  1  write strobe
- irq  out  1  level interrupt, wired to one bit of io_interrupts
- tx  out  1  serial output, idle high

## Operation
- Register offsets (addr[2:0]):
  - 0 DATA: write pushes to the FIFO; reads 0.
  - 1 STAT: read-only; bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky); any write clears overflow.
  - 2 CTRL: R/W; bit0 enable, bit1 irq_en; other bits read 0.
  - 3 DIVL, 4 DIVH: R/W, 16-bit divisor.
  - 5–7: read 0; writes are ignored.
- Bus: a write is accepted on a clk edge when io_write_en = 1 and io_writeaddr[4:3] == BANK. Reads from another bank return 8'h00.
- DATA write with FIFO full: byte dropped and overflow set. Exception: if the FSM pops in the same cycle, the push is accepted and the count is unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when enable = 1 and the FIFO is non-empty; pops the head into the shift register.
  - START -> DATA after one bit period.
  - DATA shifts LSB first for 8 bit periods, then -> STOP.
  - At the end of STOP: if enable = 1 and the FIFO is non-empty, pop and go directly to START with no idle cycle; otherwise go to IDLE.
- tx levels: 0 in START, the data bit in DATA, 1 in STOP and IDLE.
- Bit period is DIV+1 clocks. DIV = 0 gives 1 clock per bit.
- DIV is sampled at each bit boundary; a mid-frame change takes effect from the next bit.
- Clearing enable mid-frame: the current frame completes, then the FSM stays in IDLE. FIFO contents are retained.
- irq = irq_en & empty & (state == IDLE). It stays asserted until irq_en is cleared or a DATA write arrives.

## Timing
- Reset values:
  - Outputs: tx = 1, irq = 0, io_readdata = 0.
  - Registers: CTRL = 0, DIV = DIV_RESET, FIFO empty, overflow = 0, state IDLE.
- Reset mid-frame: tx = 1 from the next edge, and the frame is abandoned.
- Read latency is 1 cycle. io_readdata is registered from io_readaddr at each edge where pause = 0, and holds while pause = 1. This matches the controller, which consumes it in the cycle after presenting the address.
- Read-after-write: a write at edge N is visible to a read addressed in the cycle after N, i.e. data appears after edge N+1. There is no bypass.
- Start latency: a DATA write at edge N with enable = 1 and the FSM idle causes the pop and tx = 0 at edge N+1.
- Frame length is exactly 10×(DIV+1) clocks. A back-to-back frame's start bit begins the clock after the previous stop bit ends.
- irq deasserts at the edge that accepts a DATA write or enters START.

## Structure
- Package io_uart_pkg holds:
  - offset constants OFF_DATA, OFF_STAT, OFF_CTRL, OFF_DIVL, OFF_DIVH;
  - STAT/CTRL bit indices;
  - the FSM state encoding.
- Sub-module io_fifo: synchronous FIFO with push, pop, full, empty and a same-cycle push+pop-when-full rule; parameterised width and depth.
- Top level holds the bus decode, registers, baud counter, bit counter and FSM.

## Test plan
- Reset and idle: hold reset = 0 for 2 cycles, then read all offsets → tx = 1, irq = 0, STAT = 8'h02, CTRL = 0, DIVL = 8'hB1, DIVH = 8'h01.
- Single frame: DIV = 3, CTRL = 1, write DATA 8'hA5 → tx sequence, each level held 4 clocks: 0, 1,0,1,0,0,1,0,1, 1; total 40 clocks; start bit one edge after the write.
- Back-to-back and overflow: DIV = 0, CTRL = 1, write 6 bytes in consecutive cycles →
  - the first 5 are accepted (one popped immediately, 4 in the FIFO);
  - the 6th is dropped and STAT bit3 = 1;
  - 50 contiguous tx bit-clocks with no gap;
  - a STAT write clears bit3.
- Interrupt: CTRL = 3, send 1 byte → irq rises the cycle after STOP ends; a DATA write clears it; clearing irq_en also clears it.
- Bank decode and pause: with BANK = 2, write at bank 1 offset 2 → CTRL is unchanged. Read STAT with pause held 3 cycles → io_readdata is stable throughout.
- Mid-frame events:
  - change DIV from 3 to 1 during bit 3 → bit 4 onward lasts 2 clocks;
  - clear enable mid-frame → the frame finishes and the queued byte is held;
  - assert reset mid-frame → tx = 1 at the next edge.
